// File: rtl/lut_pkg.sv
// Shared FSM state type and sizing helpers for lut_eval_sweep and its sweep controller.
package lut_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } lut_state_e;

  // Width of the RST_TABLE parameter; rows beyond it reset to zero.
  localparam int LUT_RST_BITS = 64;

  function automatic int lut_depth(input int n_in);
    return 2 ** n_in;
  endfunction

  // One extra bit so an all-ones channel reads 2^N_IN instead of wrapping to 0.
  function automatic int lut_cnt_w(input int n_in);
    return n_in + 1;
  endfunction

endpackage

// File: rtl/lut_sweep_ctrl.sv
// Sweep sequencer: IDLE -> SWEEP (one row index per cycle) -> DONE -> IDLE,
// with registered busy/done flags aligned to the registered evaluation outputs.
module lut_sweep_ctrl
  import lut_pkg::*;
#(
  parameter int N_IN = 4
)(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_start,
  output lut_state_e      o_state,
  output logic [N_IN-1:0] o_idx,
  output logic            o_busy,
  output logic            o_done
);

  lut_state_e      r_state;
  logic [N_IN-1:0] r_idx;
  logic            r_busy;
  logic            r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      // Flags lag the state by one edge, matching the output register stage.
      r_busy <= (r_state == ST_SWEEP);
      r_done <= (r_state == ST_DONE);
      unique case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state <= ST_SWEEP;
            r_idx   <= '0;
          end
        end
        ST_SWEEP: begin
          r_idx <= r_idx + 1'b1;
          if (r_idx == '1) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_state = r_state;
  assign o_idx   = r_idx;
  assign o_busy  = r_busy;
  assign o_done  = r_done;

endmodule

// File: rtl/lut_eval_sweep.sv
// Writable N_OUT-channel truth table over N_IN inputs with registered evaluation and a
// hardware minterm-count sweep. Define LUT_RST_TABLE_EN to reset channel 0 to RST_TABLE.
module lut_eval_sweep
  import lut_pkg::*;
#(
  parameter int                      N_IN      = 4,
  parameter int                      N_OUT     = 1,
  parameter logic [LUT_RST_BITS-1:0] RST_TABLE = 64'hB1B1
)(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cfg_we,
  input  logic [N_IN-1:0]              cfg_addr,
  input  logic [N_OUT-1:0]             cfg_data,
  input  logic                         in_valid,
  input  logic [N_IN-1:0]              in_vec,
  input  logic                         sweep_start,
  output logic                         out_valid,
  output logic [N_OUT-1:0]             out_vec,
  output logic [N_IN-1:0]              out_idx,
  output logic                         sweep_busy,
  output logic                         sweep_done,
  output logic [N_OUT*(N_IN+1)-1:0]    ones_cnt
);

  localparam int DEPTH = lut_depth(N_IN);
  localparam int CW    = lut_cnt_w(N_IN);

`ifdef LUT_RST_TABLE_EN
  localparam bit RST_EN = 1'b1;
`else
  localparam bit RST_EN = 1'b0;
`endif

  function automatic logic [N_OUT-1:0] row_reset(input int row);
    logic [N_OUT-1:0] v;
    v = '0;
    if (RST_EN && (row < LUT_RST_BITS)) begin
      v[0] = RST_TABLE[row[5:0]];
    end
    return v;
  endfunction

  lut_state_e       w_state;
  logic [N_IN-1:0]  w_idx;
  logic             w_busy;
  logic             w_done;
  logic             w_idle;
  logic             w_sweeping;
  logic             w_start_acc;
  logic             w_wr_en;
  logic             w_eval;
  logic [N_IN-1:0]  w_rd_addr;
  logic [N_OUT-1:0] w_rd_row;
  logic [N_OUT-1:0] w_rows [DEPTH];

  logic             r_out_valid;
  logic [N_OUT-1:0] r_out_vec;
  logic [N_IN-1:0]  r_out_idx;

  lut_sweep_ctrl #(
    .N_IN (N_IN)
  ) u_ctrl (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (sweep_start),
    .o_state (w_state),
    .o_idx   (w_idx),
    .o_busy  (w_busy),
    .o_done  (w_done)
  );

  assign w_idle      = (w_state == ST_IDLE);
  assign w_sweeping  = (w_state == ST_SWEEP);
  assign w_start_acc = w_idle && sweep_start;
  // A cycle that accepts a sweep swallows both the write and the evaluation.
  assign w_wr_en     = w_idle && cfg_we && !sweep_start;
  assign w_eval      = w_idle && in_valid && !sweep_start;

  // One read port shared by evaluation and sweep; rows are read before same-edge writes land.
  assign w_rd_addr = w_sweeping ? w_idx : in_vec;
  assign w_rd_row  = w_rows[w_rd_addr];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_row
    localparam logic [N_OUT-1:0] ROW_RST = row_reset(gi);
    logic [N_OUT-1:0] r_row;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_row <= ROW_RST;
      end else if (w_wr_en && (cfg_addr == N_IN'(gi))) begin
        r_row <= cfg_data;
      end
    end

    assign w_rows[gi] = r_row;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_vec   <= '0;
      r_out_idx   <= '0;
    end else begin
      r_out_valid <= 1'b0;
      if (w_sweeping) begin
        r_out_valid <= 1'b1;
        r_out_vec   <= w_rd_row;
        r_out_idx   <= w_idx;
      end else if (w_eval) begin
        r_out_valid <= 1'b1;
        r_out_vec   <= w_rd_row;
        r_out_idx   <= in_vec;
      end
    end
  end

  for (genvar gi = 0; gi < N_OUT; gi++) begin : g_cnt
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
      end else if (w_start_acc) begin
        r_cnt <= '0;
      end else if (w_sweeping) begin
        r_cnt <= r_cnt + CW'(w_rd_row[gi]);
      end
    end

    assign ones_cnt[gi*CW +: CW] = r_cnt;
  end

  assign out_valid  = r_out_valid;
  assign out_vec    = r_out_vec;
  assign out_idx    = r_out_idx;
  assign sweep_busy = w_busy;
  assign sweep_done = w_done;

endmodule

// File: tb/tb_lut_eval_sweep.sv
// Self-checking bench for lut_eval_sweep (N_IN=4, N_OUT=2): table vectors, sweeps,
// randomized write/evaluate traffic against an array model, and a mid-sweep reset.
module tb_lut_eval_sweep;

  localparam int N_IN  = 4;
  localparam int N_OUT = 2;
  localparam int DEPTH = 1 << N_IN;
  localparam int CW    = N_IN + 1;

  typedef struct {
    logic             we;
    logic [N_IN-1:0]  waddr;
    logic [N_OUT-1:0] wdata;
    logic             rd;
    logic [N_IN-1:0]  raddr;
    logic [N_OUT-1:0] exp_vec;
  } vec_t;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  cfg_we = 1'b0;
  logic [N_IN-1:0]       cfg_addr = '0;
  logic [N_OUT-1:0]      cfg_data = '0;
  logic                  in_valid = 1'b0;
  logic [N_IN-1:0]       in_vec = '0;
  logic                  sweep_start = 1'b0;
  logic                  out_valid;
  logic [N_OUT-1:0]      out_vec;
  logic [N_IN-1:0]       out_idx;
  logic                  sweep_busy;
  logic                  sweep_done;
  logic [N_OUT*CW-1:0]   ones_cnt;

  int checks = 0;
  int errors = 0;
  logic [N_OUT-1:0] model [DEPTH];
  vec_t vecs [8];

  always #5 clk = ~clk;

  lut_eval_sweep #(
    .N_IN  (N_IN),
    .N_OUT (N_OUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .in_valid    (in_valid),
    .in_vec      (in_vec),
    .sweep_start (sweep_start),
    .out_valid   (out_valid),
    .out_vec     (out_vec),
    .out_idx     (out_idx),
    .sweep_busy  (sweep_busy),
    .sweep_done  (sweep_done),
    .ones_cnt    (ones_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
`ifdef LUT_RST_TABLE_EN
    logic [15:0] rst_bits;
    rst_bits = 16'hB1B1;
`endif
    for (int r = 0; r < DEPTH; r++) begin
      model[r] = '0;
`ifdef LUT_RST_TABLE_EN
      model[r][0] = rst_bits[r];
`endif
    end
  endfunction

  function automatic int model_ones(input int ch);
    int n;
    n = 0;
    for (int r = 0; r < DEPTH; r++) n += int'(model[r][ch]);
    return n;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 0);
    check({tag, "_out_vec"}, 32'(out_vec), 0);
    check({tag, "_out_idx"}, 32'(out_idx), 0);
    check({tag, "_busy"}, 32'(sweep_busy), 0);
    check({tag, "_done"}, 32'(sweep_done), 0);
    check({tag, "_ones_cnt"}, 32'(ones_cnt), 0);
  endtask

  task automatic wr(input logic [N_IN-1:0] a, input logic [N_OUT-1:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
    model[a] = d;
  endtask

  task automatic eval(input logic [N_IN-1:0] a);
    in_valid = 1'b1; in_vec = a;
    @(negedge clk);
    in_valid = 1'b0;
    check($sformatf("eval%0d_valid", a), 32'(out_valid), 1);
    check($sformatf("eval%0d_idx", a), 32'(out_idx), 32'(a));
    check($sformatf("eval%0d_vec", a), 32'(out_vec), 32'(model[a]));
    @(negedge clk);
    check($sformatf("eval%0d_idle_valid", a), 32'(out_valid), 0);
    check($sformatf("eval%0d_hold_vec", a), 32'(out_vec), 32'(model[a]));
  endtask

  // Full sweep; with disturb set, sweep_start stays high and write/evaluate pulses
  // hit every sweep cycle, none of which may change the table or the output stream.
  task automatic run_sweep(input bit disturb, input string tag);
    sweep_start = 1'b1;
    cfg_we = disturb; cfg_addr = 4'd6; cfg_data = ~model[6];
    in_valid = disturb; in_vec = 4'd3;
    @(negedge clk);
    check({tag, "_accept_valid"}, 32'(out_valid), 0);
    check({tag, "_accept_busy"}, 32'(sweep_busy), 0);
    if (!disturb) sweep_start = 1'b0;
    cfg_we = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (disturb) begin
        cfg_we = 1'b1; cfg_addr = N_IN'($urandom); cfg_data = N_OUT'($urandom);
        in_valid = 1'($urandom_range(0, 1)); in_vec = N_IN'($urandom);
      end
      @(negedge clk);
      check($sformatf("%s_i%0d_valid", tag, i), 32'(out_valid), 1);
      check($sformatf("%s_i%0d_busy", tag, i), 32'(sweep_busy), 1);
      check($sformatf("%s_i%0d_done", tag, i), 32'(sweep_done), 0);
      check($sformatf("%s_i%0d_idx", tag, i), 32'(out_idx), i);
      check($sformatf("%s_i%0d_vec", tag, i), 32'(out_vec), 32'(model[i]));
    end
    sweep_start = 1'b0; cfg_we = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(sweep_done), 1);
    check({tag, "_done_busy"}, 32'(sweep_busy), 0);
    check({tag, "_done_valid"}, 32'(out_valid), 0);
    @(negedge clk);
    check({tag, "_done_single"}, 32'(sweep_done), 0);
    for (int ch = 0; ch < N_OUT; ch++) begin
      check($sformatf("%s_ones_ch%0d", tag, ch), 32'(ones_cnt[ch*CW +: CW]), model_ones(ch));
    end
    $display("sweep %s: ones ch0=%0d ch1=%0d", tag, model_ones(0), model_ones(1));
  endtask

  initial begin
    logic [N_IN-1:0]  wa, ra;
    logic [N_OUT-1:0] wd, last_vec;
    logic [N_IN-1:0]  last_idx;
    int op;

    // Hand-computed against the pattern row r = r[1:0] written just before the loop.
    vecs[0] = '{1'b0, 4'd0,  2'b00, 1'b1, 4'd9,  2'b01};
    vecs[1] = '{1'b1, 4'd5,  2'b11, 1'b1, 4'd5,  2'b01};
    vecs[2] = '{1'b0, 4'd0,  2'b00, 1'b1, 4'd5,  2'b11};
    vecs[3] = '{1'b1, 4'd0,  2'b10, 1'b0, 4'd0,  2'b00};
    vecs[4] = '{1'b0, 4'd0,  2'b00, 1'b1, 4'd0,  2'b10};
    vecs[5] = '{1'b0, 4'd0,  2'b00, 1'b1, 4'd15, 2'b11};
    vecs[6] = '{1'b1, 4'd15, 2'b00, 1'b1, 4'd14, 2'b10};
    vecs[7] = '{1'b0, 4'd0,  2'b00, 1'b1, 4'd15, 2'b00};

    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run_sweep(1'b0, "rst_table");

    wr(4'd3, 2'b01);
    wr(4'd15, 2'b01);
    run_sweep(1'b0, "two_rows");

    for (int r = 0; r < DEPTH; r++) wr(N_IN'(r), N_OUT'(r));
    last_vec = '0; last_idx = '0;
    for (int v = 0; v < 8; v++) begin
      cfg_we = vecs[v].we; cfg_addr = vecs[v].waddr; cfg_data = vecs[v].wdata;
      in_valid = vecs[v].rd; in_vec = vecs[v].raddr;
      @(negedge clk);
      cfg_we = 1'b0; in_valid = 1'b0;
      if (vecs[v].rd) begin
        last_vec = vecs[v].exp_vec;
        last_idx = vecs[v].raddr;
      end
      check($sformatf("vec%0d_valid", v), 32'(out_valid), 32'(vecs[v].rd));
      check($sformatf("vec%0d_vec", v), 32'(out_vec), 32'(last_vec));
      check($sformatf("vec%0d_idx", v), 32'(out_idx), 32'(last_idx));
      if (vecs[v].we) model[vecs[v].waddr] = vecs[v].wdata;
      $display("vector %0d: we=%0d row%0d<=%0h rd=%0d row%0d exp=%0h", v, vecs[v].we,
               vecs[v].waddr, vecs[v].wdata, vecs[v].rd, vecs[v].raddr, vecs[v].exp_vec);
    end

    for (int r = 0; r < DEPTH; r++) wr(N_IN'(r), 2'b11);
    run_sweep(1'b0, "all_ones");
    eval(4'd9);

    for (int n = 0; n < 150; n++) begin
      op = $urandom_range(0, 2);
      wa = N_IN'($urandom); ra = N_IN'($urandom); wd = N_OUT'($urandom);
      if (op == 0) begin
        wr(wa, wd);
      end else if (op == 1) begin
        eval(ra);
      end else begin
        if ($urandom_range(0, 1) == 1) ra = wa;
        cfg_we = 1'b1; cfg_addr = wa; cfg_data = wd;
        in_valid = 1'b1; in_vec = ra;
        @(negedge clk);
        cfg_we = 1'b0; in_valid = 1'b0;
        check($sformatf("rnd%0d_valid", n), 32'(out_valid), 1);
        check($sformatf("rnd%0d_vec", n), 32'(out_vec), 32'(model[ra]));
        model[wa] = wd;
      end
    end
    run_sweep(1'b0, "random");
    run_sweep(1'b1, "disturbed");
    run_sweep(1'b0, "after_disturb");

    sweep_start = 1'b1;
    @(negedge clk);
    sweep_start = 1'b0;
    repeat (8) @(negedge clk);
    check("midrst_pre_idx", 32'(out_idx), 7);
    check("midrst_pre_busy", 32'(sweep_busy), 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("midrst_no_done", 32'(sweep_done), 0);
    rst_n = 1'b1;
    @(negedge clk);
    run_sweep(1'b0, "post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
